// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-byte holding buffer feeding a shift register,
// framed as start / 8 data (LSB first) / optional even parity / stop.
module uart_tx_framer #(
  parameter int BIT_COUNTS = 5210,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] Tx_Data,
  input  logic       tx_send,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CW = (BIT_COUNTS > 1) ? $clog2(BIT_COUNTS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_COUNTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt, cnt_nx;
  logic [2:0]    bit_idx, idx_nx;
  logic [7:0]    shift_reg, shift_nx;
  logic          parity_bit, parity_nx;
  logic [7:0]    hold_reg;
  logic          hold_valid;
  logic          accept, load, bit_end;
  logic          tx_nx, busy_nx, done_nx;

  assign tx_ready = ~hold_valid;
  assign accept   = tx_send & ~hold_valid;
  assign bit_end  = (bit_cnt == LAST_CNT);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_valid) begin
          state_nx = S_START;
          load     = 1'b1;
        end
      end
      S_START:  if (bit_end) state_nx = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) state_nx = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (hold_valid) begin
            state_nx = S_START;
            load     = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default:  state_nx = S_IDLE;
    endcase

    shift_nx  = shift_reg;
    parity_nx = parity_bit;
    if (load) begin
      shift_nx  = hold_reg;
      parity_nx = ^hold_reg;
    end else if (state == S_DATA && bit_end) begin
      shift_nx = shift_reg >> 1;
    end

    cnt_nx = (state == S_IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
    idx_nx = (state == S_DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
    if (load) idx_nx = 3'd0;

    // Outputs are computed from the next state so they register in step with it.
    unique case (state_nx)
      S_IDLE:   tx_nx = 1'b1;
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = parity_nx;
      default:  tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_STOP) && (cnt_nx == LAST_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      hold_reg   <= 8'h00;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= cnt_nx;
      bit_idx    <= idx_nx;
      shift_reg  <= shift_nx;
      parity_bit <= parity_nx;
      tx         <= tx_nx;
      tx_busy    <= busy_nx;
      tx_done    <= done_nx;
      // Fill and drain are exclusive: accept needs hold_valid=0, load needs 1.
      if (accept) begin
        hold_reg   <= Tx_Data;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule
